// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic ops and an iterative shift-add
// multiplier, with a valid/ready handshake on both the operand and result sides.
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       s,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] f,
   output logic [3:0]       flags
);

   localparam int SW = $clog2(WIDTH);
   localparam int CW = SW + 1;

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_PASSB = 4'b0010;
   localparam logic [3:0] OP_PASSA = 4'b0011;
   localparam logic [3:0] OP_AND   = 4'b0100;
   localparam logic [3:0] OP_OR    = 4'b0101;
   localparam logic [3:0] OP_NOT   = 4'b0110;
   localparam logic [3:0] OP_XOR   = 4'b0111;
   localparam logic [3:0] OP_SLL   = 4'b1000;
   localparam logic [3:0] OP_SRA   = 4'b1001;
   localparam logic [3:0] OP_MUL   = 4'b1010;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t            state, state_nxt;
   logic              accept;
   logic              is_mul;
   logic              mul_last;
   logic [CW-1:0]     cnt;

   logic [WIDTH-1:0]  b_eff;
   logic [WIDTH:0]    sum;
   logic [SW-1:0]     shamt;
   logic [WIDTH-1:0]  alu_f;
   logic              alu_c;
   logic              alu_v;

   logic [WIDTH-1:0]  mcand;
   logic [WIDTH-1:0]  prod_hi;
   logic [WIDTH-1:0]  prod_lo;
   logic [WIDTH:0]    mul_add;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign is_mul    = (s == OP_MUL);
   // After WIDTH iterations the counter sits at WIDTH for one final cycle
   // in which the product is copied into f/flags.
   assign mul_last  = (cnt == CW'(WIDTH));

   // ---------------- single-cycle ALU, evaluated on the live inputs at accept
   assign b_eff = (s == OP_SUB) ? ~b : b;
   assign sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
   assign shamt = b[SW-1:0];

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case can leave a value unassigned and infer a latch.
   always_comb begin
      alu_f = sum[WIDTH-1:0];
      alu_c = 1'b0;
      alu_v = 1'b0;
      case (s)
         OP_PASSB: alu_f = b;
         OP_PASSA: alu_f = a;
         OP_AND:   alu_f = a & b;
         OP_OR:    alu_f = a | b;
         OP_NOT:   alu_f = ~a;
         OP_XOR:   alu_f = a ^ b;
         OP_SLL:   alu_f = a << shamt;
         OP_SRA:   alu_f = $signed(a) >>> shamt;
         OP_MUL:   alu_f = '0;
         default: begin
            // ADD, SUB and the reserved opcodes share the adder
            alu_f = sum[WIDTH-1:0];
            alu_c = sum[WIDTH];
            alu_v = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
      endcase
   end

   // ---------------- shift-add multiplier step: {hi,lo} holds partial product / multiplier
   assign mul_add = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});

   // ---------------- control FSM
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid) state_nxt = is_mul ? BUSY : DONE;
         BUSY: if (mul_last) state_nxt = DONE;
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         f     <= '0;
         flags <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cnt <= '0;
            if (!is_mul) begin
               f     <= alu_f;
               flags <= {alu_f[WIDTH-1], (alu_f == '0), alu_c, alu_v};
            end
         end else if (state == BUSY) begin
            if (!mul_last) begin
               cnt <= cnt + 1'b1;
            end else begin
               f     <= prod_lo;
               flags <= {prod_lo[WIDTH-1], (prod_lo == '0), (prod_hi != '0), 1'b0};
            end
         end
      end
   end

   // NOTE: multiplier datapath registers carry no reset; they are always loaded
   // at accept before being read, and reset aborts through the FSM alone.
   always_ff @(posedge clk) begin
      if (accept) begin
         mcand   <= a;
         prod_hi <= '0;
         prod_lo <= b;
      end else if (state == BUSY && !mul_last) begin
         {prod_hi, prod_lo} <= {mul_add, prod_lo[WIDTH-1:1]};
      end
   end

endmodule
